// File: rtl/dh_apb_sequencer.sv
// APB master that loads operands into the DH engine, kicks it, polls for
// completion and reads the result window back as one parallel word.
module dh_apb_sequencer #(
  parameter int unsigned NWORDS     = 9,
  parameter logic [31:0] A_BASE     = 32'h00,
  parameter logic [31:0] B_BASE     = 32'h24,
  parameter logic [31:0] GO_ADDR    = 32'h54,
  parameter logic [31:0] DONE_ADDR  = 32'h60,
  parameter logic [31:0] C_BASE     = 32'h64,
  parameter int unsigned POLL_LIMIT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [32*NWORDS-1:0]     a_in,
  input  logic [32*NWORDS-1:0]     b_in,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [1:0]               err_code,
  output logic [32*NWORDS-1:0]     c_out,
  output logic                     M_PSEL,
  output logic                     M_PENABLE,
  output logic [31:0]              M_PADDR,
  output logic                     M_PWRITE,
  output logic [31:0]              M_PWDATA,
  input  logic                     M_PREADY,
  input  logic                     M_PSLVERR,
  input  logic [31:0]              M_PRDATA
);

  localparam int unsigned IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int unsigned PW = $clog2(POLL_LIMIT + 1);
  localparam logic [IW-1:0] LastIdx  = IW'(NWORDS - 1);
  localparam logic [PW-1:0] LastPoll = PW'(POLL_LIMIT - 1);

  typedef enum logic [3:0] {
    StIdle, StWrA, StWrB, StGoSet, StGoClr, StPoll, StRdC, StFin, StErr
  } state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 access_q, access_d;   // 0: SETUP phase, 1: ACCESS phase
  logic [PW-1:0]        poll_q, poll_d;
  logic [1:0]           kind_q, kind_d;       // error code pending for the ERR state
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic [1:0]           code_q, code_d;
  logic [32*NWORDS-1:0] a_q, a_d, b_q, b_d, shadow_q, shadow_d, c_q, c_d;
  logic                 xfer;
  logic [31:0]          word_off;

  assign word_off = 32'(idx_q) << 2;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign err_code = code_q;
  assign c_out    = c_q;

  // Control state; synchronous reset abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      access_q <= 1'b0;
      poll_q   <= '0;
      kind_q   <= 2'b00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      code_q   <= 2'b00;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      access_q <= access_d;
      poll_q   <= poll_d;
      kind_q   <= kind_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      code_q   <= code_d;
    end
  end

  // Operand latches, read-back shadow and the published result.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      shadow_q <= '0;
      c_q      <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      shadow_q <= shadow_d;
      c_q      <= c_d;
    end
  end

  // Next-state, APB drive and completion reporting.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    access_d  = access_q;
    poll_d    = poll_q;
    kind_d    = kind_q;
    busy_d    = busy_q & ~done_q;
    done_d    = 1'b0;
    error_d   = error_q;
    code_d    = code_q;
    a_d       = a_q;
    b_d       = b_q;
    shadow_d  = shadow_q;
    c_d       = c_q;
    xfer      = 1'b0;
    M_PSEL    = 1'b0;
    M_PENABLE = 1'b0;
    M_PADDR   = '0;
    M_PWRITE  = 1'b0;
    M_PWDATA  = '0;

    case (state_q)
      StIdle: begin
        if (start && !busy_q) begin
          a_d      = a_in;
          b_d      = b_in;
          idx_d    = '0;
          access_d = 1'b0;
          poll_d   = '0;
          busy_d   = 1'b1;
          error_d  = 1'b0;
          code_d   = 2'b00;
          state_d  = StWrA;
        end
      end
      StWrA: begin
        xfer     = 1'b1;
        M_PWRITE = 1'b1;
        M_PADDR  = A_BASE + word_off;
        M_PWDATA = a_q[32*idx_q +: 32];
      end
      StWrB: begin
        xfer     = 1'b1;
        M_PWRITE = 1'b1;
        M_PADDR  = B_BASE + word_off;
        M_PWDATA = b_q[32*idx_q +: 32];
      end
      StGoSet: begin
        xfer     = 1'b1;
        M_PWRITE = 1'b1;
        M_PADDR  = GO_ADDR;
        M_PWDATA = 32'd1;
      end
      StGoClr: begin
        xfer     = 1'b1;
        M_PWRITE = 1'b1;
        M_PADDR  = GO_ADDR;
      end
      StPoll: begin
        xfer    = 1'b1;
        M_PADDR = DONE_ADDR;
      end
      StRdC: begin
        xfer    = 1'b1;
        M_PADDR = C_BASE + word_off;
      end
      StFin: begin
        c_d     = shadow_q;
        done_d  = 1'b1;
        error_d = 1'b0;
        code_d  = 2'b00;
        state_d = StIdle;
      end
      StErr: begin
        done_d  = 1'b1;
        error_d = 1'b1;
        code_d  = kind_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (xfer) begin
      M_PSEL    = 1'b1;
      M_PENABLE = access_q;
      if (!access_q) begin
        access_d = 1'b1;
      end else if (M_PREADY) begin
        access_d = 1'b0;
        if (M_PSLVERR) begin
          kind_d  = 2'b01;
          idx_d   = '0;
          state_d = StErr;
        end else begin
          case (state_q)
            StWrA, StWrB, StRdC: begin
              if (state_q == StRdC) shadow_d[32*idx_q +: 32] = M_PRDATA;
              if (idx_q == LastIdx) begin
                idx_d   = '0;
                state_d = (state_q == StWrA) ? StWrB :
                          (state_q == StWrB) ? StGoSet : StFin;
              end else begin
                idx_d = idx_q + 1'b1;
              end
            end
            StGoSet: state_d = StGoClr;
            StGoClr: begin
              poll_d  = '0;
              state_d = StPoll;
            end
            StPoll: begin
              if (M_PRDATA[0]) begin
                poll_d  = '0;
                state_d = StRdC;
              end else if (poll_q == LastPoll) begin
                kind_d  = 2'b10;
                state_d = StErr;
              end else begin
                poll_d = poll_q + 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_dh_apb_sequencer.sv
// Self-checking bench: APB slave model plus a transaction-list reference model.
module tb_dh_apb_sequencer;

  localparam int unsigned NW = 9;
  localparam int unsigned PL = 4;
  localparam int unsigned W  = 32 * NW;
  localparam logic [31:0] A_BASE    = 32'h00;
  localparam logic [31:0] B_BASE    = 32'h24;
  localparam logic [31:0] GO_ADDR   = 32'h54;
  localparam logic [31:0] DONE_ADDR = 32'h60;
  localparam logic [31:0] C_BASE    = 32'h64;
  localparam logic [31:0] NO_ERR    = 32'hFFFF_FFFF;
  localparam int          MAX_CYC   = 3000;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
  } xfer_t;

  logic         clk, rst, start;
  logic [W-1:0] a_in, b_in, c_out;
  logic         busy, done, error;
  logic [1:0]   err_code;
  logic         M_PSEL, M_PENABLE, M_PWRITE, M_PREADY, M_PSLVERR;
  logic [31:0]  M_PADDR, M_PWDATA, M_PRDATA;

  // Slave configuration and bookkeeping.
  int           cfg_wait;       // <0: random 0..2 wait states per access
  int           cfg_done_poll;  // poll number (1-based) that returns done; 0 = never
  logic [31:0]  cfg_err_addr;
  logic [31:0]  cx [NW];
  int           polls, polls_base, wcnt, wtgt, stab_err, done_cnt;
  logic [31:0]  s_addr, s_data;
  logic         s_wr, done_now;
  xfer_t        log_q [$];
  logic [W-1:0] exp_c;
  int           npass, nchk;

  dh_apb_sequencer #(
    .NWORDS    (NW),
    .A_BASE    (A_BASE),
    .B_BASE    (B_BASE),
    .GO_ADDR   (GO_ADDR),
    .DONE_ADDR (DONE_ADDR),
    .C_BASE    (C_BASE),
    .POLL_LIMIT(PL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .err_code (err_code),
    .c_out    (c_out),
    .M_PSEL   (M_PSEL),
    .M_PENABLE(M_PENABLE),
    .M_PADDR  (M_PADDR),
    .M_PWRITE (M_PWRITE),
    .M_PWDATA (M_PWDATA),
    .M_PREADY (M_PREADY),
    .M_PSLVERR(M_PSLVERR),
    .M_PRDATA (M_PRDATA)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign done_now  = (cfg_done_poll > 0) && ((polls - polls_base + 1) >= cfg_done_poll);
  assign M_PREADY  = M_PSEL && M_PENABLE && (wcnt >= wtgt);
  assign M_PSLVERR = M_PSEL && M_PENABLE && (M_PADDR == cfg_err_addr);

  // Read data: done flag or the result window.
  always_comb begin
    M_PRDATA = 32'hDEAD_BEEF;
    if (M_PADDR == DONE_ADDR) M_PRDATA = {31'd0, done_now};
    for (int k = 0; k < NW; k++)
      if (M_PADDR == C_BASE + 32'(4 * k)) M_PRDATA = cx[k];
  end

  // Slave protocol tracking: wait states, stability, transfer log.
  initial begin
    polls = 0; wcnt = 0; wtgt = 0; stab_err = 0; done_cnt = 0;
    s_addr = '0; s_data = '0; s_wr = 1'b0;
  end
  always @(posedge clk) begin
    if (M_PSEL && !M_PENABLE) begin
      s_addr <= M_PADDR;
      s_wr   <= M_PWRITE;
      s_data <= M_PWDATA;
      wcnt   <= 0;
      wtgt   <= (cfg_wait < 0) ? int'($urandom_range(0, 2)) : cfg_wait;
    end else if (M_PSEL && M_PENABLE) begin
      if (M_PADDR !== s_addr || M_PWRITE !== s_wr || M_PWDATA !== s_data)
        stab_err <= stab_err + 1;
      if (M_PREADY) begin
        log_q.push_back({M_PADDR, M_PWRITE, (M_PWRITE ? M_PWDATA : 32'd0)});
        if (!M_PWRITE && M_PADDR == DONE_ADDR) polls <= polls + 1;
      end else begin
        wcnt <= wcnt + 1;
      end
    end
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    nchk++;
    assert (obs === expv) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  function automatic logic [W-1:0] cx_packed();
    logic [W-1:0] v;
    for (int k = 0; k < NW; k++) v[32*k +: 32] = cx[k];
    return v;
  endfunction

  // One operation: build the expected transfer list, drive start, check everything.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int extra_start, output int lat, output int nx);
    xfer_t      exp_q [$];
    logic       done_found;
    logic [1:0] exp_code;
    int         np, base, dbase, sbase, cyc, mism;

    for (int k = 0; k < NW; k++) exp_q.push_back({A_BASE + 32'(4 * k), 1'b1, a[32*k +: 32]});
    for (int k = 0; k < NW; k++) exp_q.push_back({B_BASE + 32'(4 * k), 1'b1, b[32*k +: 32]});
    exp_q.push_back({GO_ADDR, 1'b1, 32'd1});
    exp_q.push_back({GO_ADDR, 1'b1, 32'd0});
    done_found = (cfg_done_poll >= 1) && (cfg_done_poll <= PL);
    np = done_found ? cfg_done_poll : PL;
    for (int p = 0; p < np; p++) exp_q.push_back({DONE_ADDR, 1'b0, 32'd0});
    if (done_found)
      for (int k = 0; k < NW; k++) exp_q.push_back({C_BASE + 32'(4 * k), 1'b0, 32'd0});
    exp_code = done_found ? 2'b00 : 2'b10;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].addr == cfg_err_addr) begin
        while (exp_q.size() > i + 1) void'(exp_q.pop_back());
        exp_code = 2'b01;
        break;
      end
    end
    if (exp_code == 2'b00) exp_c = cx_packed();
    nx = exp_q.size();

    base = log_q.size(); dbase = done_cnt; sbase = stab_err; polls_base = polls;
    @(negedge clk);
    a_in = a; b_in = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < MAX_CYC) begin
      start = (cyc == extra_start) ? 1'b1 : 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    lat = cyc;
    check({name, "/done_seen"}, W'(cyc < MAX_CYC), W'(1));
    check({name, "/error"},     W'(error), W'(exp_code != 2'b00));
    check({name, "/err_code"},  W'(err_code), W'(exp_code));
    check({name, "/c_out"},     c_out, exp_c);
    check({name, "/busy_at_done"}, W'(busy), W'(1));
    @(negedge clk);
    check({name, "/done_pulse"}, W'(done), W'(0));
    check({name, "/busy_after"}, W'(busy), W'(0));
    check({name, "/psel_idle"},  W'(M_PSEL), W'(0));
    check({name, "/done_count"}, W'(done_cnt - dbase), W'(1));
    check({name, "/stable"},     W'(stab_err - sbase), W'(0));
    check({name, "/xfer_count"}, W'(log_q.size() - base), W'(nx));
    mism = 0;
    for (int i = 0; i < nx; i++)
      if (base + i >= log_q.size() || log_q[base + i] !== exp_q[i]) mism++;
    check({name, "/xfer_order"}, W'(mism), W'(0));
  endtask

  initial begin
    logic [W-1:0] a, b;
    int           l0, l1, n0, n1, cyc, sel;
    logic [31:0]  av [NW];
    logic [31:0]  bv [NW];

    npass = 0; nchk = 0;
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
    cfg_wait = 0; cfg_done_poll = 3; cfg_err_addr = NO_ERR; polls_base = 0;
    exp_c = '0;
    for (int k = 0; k < NW; k++) cx[k] = 32'hC0 + 32'(k);
    repeat (3) @(negedge clk);
    check("reset/psel",     W'(M_PSEL), W'(0));
    check("reset/penable",  W'(M_PENABLE), W'(0));
    check("reset/busy",     W'(busy), W'(0));
    check("reset/done",     W'(done), W'(0));
    check("reset/error",    W'(error), W'(0));
    check("reset/err_code", W'(err_code), W'(0));
    check("reset/c_out",    c_out, W'(0));
    rst = 1'b0;

    // Directed operands from the basic-run vector.
    av = '{32'h2, 32'h4, 32'h6, 32'h8, 32'hA, 32'hC, 32'hE, 32'h12, 32'h14};
    bv = '{32'h12, 32'h14, 32'h16, 32'h18, 32'h1A, 32'h1C, 32'h1E, 32'h22, 32'h24};
    for (int k = 0; k < NW; k++) begin
      a[32*k +: 32] = av[k];
      b[32*k +: 32] = bv[k];
    end

    run_op("basic", a, b, 0, l0, n0);
    cfg_wait = 2;
    run_op("waits", a, b, 0, l1, n1);
    check("waits/latency_delta", W'(l1 - l0), W'(2 * n1));

    cfg_wait = 0; cfg_err_addr = 32'h30;
    run_op("pslverr", a ^ {W{1'b1}}, b, 0, l1, n1);

    cfg_err_addr = NO_ERR; cfg_done_poll = 0;
    run_op("timeout", a, b, 0, l1, n1);

    cfg_done_poll = PL;
    for (int k = 0; k < NW; k++) cx[k] = 32'h5A00 + 32'(k);
    run_op("last_poll", b, a, 0, l1, n1);

    cfg_done_poll = 1;
    run_op("start_in_wrb", a, b, 2 * NW + 4, l1, n1);

    // Reset while the master is polling the done register.
    cfg_done_poll = 0;
    @(negedge clk);
    a_in = b; b_in = a; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(M_PSEL === 1'b1 && M_PADDR == DONE_ADDR) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_poll/reached_poll", W'(cyc < 200), W'(1));
    rst = 1'b1;
    @(negedge clk);
    check("rst_poll/psel",     W'(M_PSEL), W'(0));
    check("rst_poll/penable",  W'(M_PENABLE), W'(0));
    check("rst_poll/busy",     W'(busy), W'(0));
    check("rst_poll/done",     W'(done), W'(0));
    check("rst_poll/error",    W'(error), W'(0));
    check("rst_poll/err_code", W'(err_code), W'(0));
    check("rst_poll/c_out",    c_out, W'(0));
    rst = 1'b0;
    exp_c = '0;
    cfg_done_poll = 2;
    run_op("after_rst", a, b, 0, l1, n1);

    // Randomized operations against the transaction-list model.
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < NW; k++) begin
        a[32*k +: 32] = $urandom;
        b[32*k +: 32] = $urandom;
        cx[k] = $urandom;
      end
      cfg_wait = -1;
      cfg_done_poll = int'($urandom_range(0, PL));
      sel = int'($urandom_range(0, 5));
      case (sel)
        0: cfg_err_addr = A_BASE + 32'(4 * $urandom_range(0, NW - 1));
        1: cfg_err_addr = GO_ADDR;
        2: cfg_err_addr = C_BASE + 32'(4 * $urandom_range(0, NW - 1));
        default: cfg_err_addr = NO_ERR;
      endcase
      run_op($sformatf("rand%0d", r), a, b, 0, l1, n1);
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
